// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the programmable serial pattern detector.
// State encodings, length-width helper and pattern-length clamp.
package seq_det_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'b001,
        ST_FILL = 3'b010,
        ST_HUNT = 3'b100
    } state_e;

    // Bits needed to hold a length value in the range 0..max_len.
    function automatic int len_w(input int max_len);
        return $clog2(max_len + 1);
    endfunction

    // Zero becomes 1, anything beyond max_len becomes max_len.
    function automatic int unsigned clamp_len(
        input int unsigned len,
        input int unsigned max_len
    );
        if (len == 0) begin
            return 1;
        end
        if (len > max_len) begin
            return max_len;
        end
        return len;
    endfunction

endpackage

// File: rtl/seq_det_if.sv
// Configuration, serial-stream and status bundle of the detector.
// master drives stream/config, slave is the detector itself.
interface seq_det_if
    import seq_det_pkg::*;
#(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8
);
    localparam int LEN_W = len_w(MAX_LEN);

    logic               en;
    logic               cfg_load;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic               in_valid;
    logic               seq_in;
    logic               cnt_clr;
    logic               det_out;
    logic [CNT_W-1:0]   match_cnt;
    logic               busy;

    modport master (
        output en, cfg_load, cfg_pattern, cfg_len, cfg_overlap,
        output in_valid, seq_in, cnt_clr,
        input  det_out, match_cnt, busy
    );

    modport slave (
        input  en, cfg_load, cfg_pattern, cfg_len, cfg_overlap,
        input  in_valid, seq_in, cnt_clr,
        output det_out, match_cnt, busy
    );

endinterface

// File: rtl/seq_det_sat_cnt.sv
// Saturating up-counter with synchronous clear.
// Clear together with increment yields a count of one.
module seq_det_sat_cnt #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [WIDTH-1:0] cnt_o
);

    logic [WIDTH-1:0] cnt_q;

    // Count up, stick at all-ones, clear restarts from the current increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= WIDTH'(inc_i);
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/seq_detector_param.sv
// Runtime-programmable serial pattern detector with overlap control.
// History shift register, comparator and one-hot FSM live here.
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int               MAX_LEN     = 8,
    parameter int               CNT_W       = 8,
    parameter logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'(8'b0000_0110),
    parameter int               DEF_LEN     = 3,
    parameter bit               DEF_OVERLAP = 1'b1
) (
    input logic      clk,
    input logic      rst,
    seq_det_if.slave bus
);

    localparam int LEN_W = len_w(MAX_LEN);
    localparam logic [LEN_W-1:0] RST_LEN =
        LEN_W'(clamp_len(32'(DEF_LEN), 32'(MAX_LEN)));

    state_e             state_q;
    logic [MAX_LEN-2:0] hist_q;
    logic [MAX_LEN-1:0] hist_d;
    logic [LEN_W-1:0]   fill_q;
    logic [LEN_W-1:0]   fill_d;
    logic [MAX_LEN-1:0] pat_q;
    logic [LEN_W-1:0]   len_q;
    logic               ovl_q;
    logic               det_q;
    logic [MAX_LEN-1:0] mask;
    logic [LEN_W-1:0]   len_new;
    logic               accept;
    logic               match;
    logic [CNT_W-1:0]   cnt;

    // Next history/fill for an accepted bit and the match decision.
    // Only MAX_LEN-1 old bits are kept; the newest bit completes the window.
    always_comb begin
        accept  = bus.en & bus.in_valid & ~bus.cfg_load;
        hist_d  = {hist_q, bus.seq_in};
        fill_d  = (fill_q >= len_q) ? len_q : fill_q + 1'b1;
        len_new = LEN_W'(clamp_len(32'(bus.cfg_len), 32'(MAX_LEN)));
        mask    = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            mask[i] = (LEN_W'(i) < len_q);
        end
        match = accept
              && (((hist_d ^ pat_q) & mask) == '0)
              && (fill_d >= len_q);
    end

    // FSM with config latch, history, fill and registered detect pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            hist_q  <= '0;
            fill_q  <= '0;
            pat_q   <= DEF_PATTERN;
            len_q   <= RST_LEN;
            ovl_q   <= DEF_OVERLAP;
            det_q   <= 1'b0;
        end else if (bus.cfg_load) begin
            pat_q   <= bus.cfg_pattern;
            len_q   <= len_new;
            ovl_q   <= bus.cfg_overlap;
            hist_q  <= '0;
            fill_q  <= '0;
            det_q   <= 1'b0;
            state_q <= bus.en ? ST_FILL : ST_IDLE;
        end else if (!bus.en) begin
            state_q <= ST_IDLE;
            hist_q  <= '0;
            fill_q  <= '0;
            det_q   <= 1'b0;
        end else begin
            det_q <= match;
            if (accept) begin
                hist_q <= hist_d[MAX_LEN-2:0];
                if (match && !ovl_q) begin
                    fill_q  <= '0;
                    state_q <= ST_FILL;
                end else begin
                    fill_q  <= fill_d;
                    state_q <= (fill_d == len_q) ? ST_HUNT : ST_FILL;
                end
            end else if (state_q == ST_IDLE) begin
                state_q <= ST_FILL;
            end
        end
    end

    seq_det_sat_cnt #(
        .WIDTH (CNT_W)
    ) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc_i (match),
        .clr_i (bus.cnt_clr),
        .cnt_o (cnt)
    );

    assign bus.det_out   = det_q;
    assign bus.match_cnt = cnt;
    assign bus.busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: queue-based reference model,
// directed scenarios with literal expectations, then random traffic.
module tb_seq_detector_param;
    import seq_det_pkg::*;

    localparam int ML = 8;
    localparam int LW = len_w(ML);

    logic          clk = 1'b0;
    logic          rst;
    logic          en, cfg_load, cfg_overlap;
    logic          in_valid, seq_in, cnt_clr;
    logic [ML-1:0] cfg_pattern;
    logic [LW-1:0] cfg_len;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    seq_det_if #(.MAX_LEN(ML), .CNT_W(8)) b8 ();
    seq_det_if #(.MAX_LEN(ML), .CNT_W(2)) b2 ();

    assign b8.en = en;           assign b2.en = en;
    assign b8.cfg_load = cfg_load;       assign b2.cfg_load = cfg_load;
    assign b8.cfg_pattern = cfg_pattern; assign b2.cfg_pattern = cfg_pattern;
    assign b8.cfg_len = cfg_len;         assign b2.cfg_len = cfg_len;
    assign b8.cfg_overlap = cfg_overlap; assign b2.cfg_overlap = cfg_overlap;
    assign b8.in_valid = in_valid;       assign b2.in_valid = in_valid;
    assign b8.seq_in = seq_in;           assign b2.seq_in = seq_in;
    assign b8.cnt_clr = cnt_clr;         assign b2.cnt_clr = cnt_clr;

    seq_detector_param #(.MAX_LEN(ML), .CNT_W(8)) dut8 (
        .clk (clk), .rst (rst), .bus (b8.slave)
    );
    seq_detector_param #(.MAX_LEN(ML), .CNT_W(2)) dut2 (
        .clk (clk), .rst (rst), .bus (b2.slave)
    );

    // Reference model: bits received since the last restart, kept as a queue.
    bit            q[$];
    logic [ML-1:0] m_pat;
    int            m_len;
    bit            m_ov;
    bit            m_det;
    bit            m_busy;
    int            m_c8;
    int            m_c2;

    function automatic bit tail_matches();
        if (q.size() < m_len) return 1'b0;
        for (int k = 0; k < m_len; k++) begin
            if (q[q.size() - m_len + k] != m_pat[m_len - 1 - k]) return 1'b0;
        end
        return 1'b1;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            m_pat  = 8'b0000_0110;
            m_len  = 3;
            m_ov   = 1'b1;
            m_det  = 1'b0;
            m_busy = 1'b0;
            m_c8   = 0;
            m_c2   = 0;
        end else begin
            bit hit;
            hit = 1'b0;
            if (cfg_load) begin
                m_pat  = cfg_pattern;
                m_len  = (cfg_len == 0) ? 1 : ((int'(cfg_len) > ML) ? ML : int'(cfg_len));
                m_ov   = cfg_overlap;
                m_busy = en;
                q.delete();
            end else if (!en) begin
                m_busy = 1'b0;
                q.delete();
            end else begin
                m_busy = 1'b1;
                if (in_valid) begin
                    q.push_back(seq_in);
                    if (q.size() > ML) void'(q.pop_front());
                    hit = tail_matches();
                    if (hit && !m_ov) q.delete();
                end
            end
            m_det = hit;
            if (cnt_clr) begin
                m_c8 = hit ? 1 : 0;
                m_c2 = hit ? 1 : 0;
            end else if (hit) begin
                m_c8 = (m_c8 < 255) ? m_c8 + 1 : 255;
                m_c2 = (m_c2 < 3) ? m_c2 + 1 : 3;
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Every cycle outside reset: both DUTs against the model.
    always @(negedge clk) begin
        if (!rst) begin
            chk("det8", int'(b8.det_out), int'(m_det));
            chk("det2", int'(b2.det_out), int'(m_det));
            chk("cnt8", int'(b8.match_cnt), m_c8);
            chk("cnt2", int'(b2.match_cnt), m_c2);
            chk("busy8", int'(b8.busy), int'(m_busy));
            chk("busy2", int'(b2.busy), int'(m_busy));
        end
    end

    task automatic idle();
        in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic bitin(input bit b);
        in_valid = 1'b1;
        seq_in   = b;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic load(input logic [ML-1:0] p, input int l, input bit ov);
        cfg_load    = 1'b1;
        cfg_pattern = p;
        cfg_len     = LW'(l);
        cfg_overlap = ov;
        @(negedge clk);
        cfg_load = 1'b0;
    endtask

    task automatic clr();
        cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        en = 1'b0; cfg_load = 1'b0; cfg_overlap = 1'b0;
        in_valid = 1'b0; seq_in = 1'b0; cnt_clr = 1'b0;
        cfg_pattern = '0; cfg_len = '0;
        repeat (2) @(negedge clk);
        chk("rst_det", int'(b8.det_out), 0);
        chk("rst_cnt", int'(b8.match_cnt), 0);
        chk("rst_busy", int'(b8.busy), 0);
        rst = 1'b0;
        en  = 1'b1;

        // Default 110, overlapping
        bitin(1); chk("def_b1", int'(b8.det_out), 0);
        bitin(1); bitin(0); chk("def_b3", int'(b8.det_out), 1);
        bitin(1); chk("def_b4", int'(b8.det_out), 0);
        bitin(1); bitin(0); chk("def_b6", int'(b8.det_out), 1);
        chk("def_cnt", int'(b8.match_cnt), 2);

        // 1010 overlapping
        load(8'b1010, 4, 1); clr();
        bitin(1); bitin(0); bitin(1); bitin(0); chk("ov1_b4", int'(b8.det_out), 1);
        bitin(1); chk("ov1_b5", int'(b8.det_out), 0);
        bitin(0); chk("ov1_b6", int'(b8.det_out), 1);
        chk("ov1_cnt", int'(b8.match_cnt), 2);

        // 1010 non-overlapping
        load(8'b1010, 4, 0); clr();
        bitin(1); bitin(0); bitin(1); bitin(0); chk("ov0_b4", int'(b8.det_out), 1);
        bitin(1); bitin(0); chk("ov0_b6", int'(b8.det_out), 0);
        chk("ov0_cnt", int'(b8.match_cnt), 1);

        // in_valid gaps
        load(8'b110, 3, 1);
        bitin(1); repeat (3) idle();
        bitin(1); repeat (3) idle();
        bitin(0); chk("gap_hit", int'(b8.det_out), 1);
        idle(); chk("gap_after", int'(b8.det_out), 0);

        // cfg_load mid-stream drops the same-cycle bit
        load(8'b110, 3, 1);
        bitin(1); bitin(1);
        cfg_load = 1'b1; cfg_pattern = 8'b01; cfg_len = LW'(2); cfg_overlap = 1'b1;
        in_valid = 1'b1; seq_in = 1'b0;
        @(negedge clk);
        cfg_load = 1'b0; in_valid = 1'b0;
        chk("ld_cycle", int'(b8.det_out), 0);
        bitin(0); chk("ld_b0", int'(b8.det_out), 0);
        bitin(1); chk("ld_b1", int'(b8.det_out), 1);

        // Saturation on the 2-bit counter, then clear with a match
        load(8'b110, 3, 1); clr();
        for (int i = 1; i <= 5; i++) begin
            bitin(1); bitin(1); bitin(0);
            chk("sat_cnt2", int'(b2.match_cnt), (i < 3) ? i : 3);
        end
        bitin(1); bitin(1);
        cnt_clr = 1'b1; bitin(0); cnt_clr = 1'b0;
        chk("clr_hit2", int'(b2.match_cnt), 1);
        chk("clr_hit8", int'(b8.match_cnt), 1);

        // Asynchronous reset between edges
        bitin(1); bitin(1);
        #2 rst = 1'b1;
        #1;
        chk("arst_det", int'(b8.det_out), 0);
        chk("arst_cnt", int'(b8.match_cnt), 0);
        chk("arst_busy", int'(b8.busy), 0);
        @(negedge clk);
        rst = 1'b0;
        bitin(0); chk("arst_b0", int'(b8.det_out), 0);
        bitin(1); bitin(1); bitin(0); chk("arst_hit", int'(b8.det_out), 1);
        chk("arst_cnt2", int'(b8.match_cnt), 1);

        // Random traffic against the model
        for (int n = 0; n < 4000; n++) begin
            en       = ($urandom % 16) != 0;
            cfg_load = ($urandom % 64) == 0;
            if (cfg_load) begin
                cfg_pattern = ML'($urandom);
                cfg_len     = (($urandom % 4) == 0) ? LW'($urandom) : LW'(1 + $urandom % 4);
                cfg_overlap = $urandom % 2;
            end
            in_valid = ($urandom % 4) != 0;
            seq_in   = $urandom % 2;
            cnt_clr  = ($urandom % 50) == 0;
            @(negedge clk);
        end
        cfg_load = 1'b0; cnt_clr = 1'b0; in_valid = 1'b0;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
